// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 receive-side line capture.
package hub75_pkg;

  localparam int COLS     = 64;
  localparam int ROW_W    = 5;
  localparam int PLANES   = 4;
  localparam int COL_W    = $clog2(COLS) + 1;
  localparam int IDX_W    = $clog2(COLS);
  localparam int PLANE_W  = 2;
  localparam int ON_W     = 16;
  localparam int LAST_ROW = (1 << ROW_W) - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [2:0] rgb0;
    logic [2:0] rgb1;
  } pixel_t;

  // Plane advances only while the same row is latched repeatedly.
  function automatic logic [PLANE_W-1:0] next_plane(
    input logic               have_prev,
    input logic               same_row,
    input logic [PLANE_W-1:0] plane
  );
    if (!have_prev || !same_row) return '0;
    if (plane == PLANE_W'(PLANES - 1)) return '0;
    return plane + 1'b1;
  endfunction

endpackage

// File: rtl/hub75_sync.sv
// Two-flop synchronizer with a rising-edge detect on the synchronized value.
module hub75_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;
  logic [W-1:0] prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
      prev_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign q    = sync_reg;
  assign rise = sync_reg & ~prev_reg;

endmodule

// File: rtl/hub75_line_capture.sv
// Rebuilds HUB75 panel lines from the sampled bus and drains each latched
// line as addressed pixel writes; also measures NOE on-time per line.
module hub75_line_capture
  import hub75_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lp_clk,
  input  logic                 latch,
  input  logic                 noe,
  input  logic [ROW_W-1:0]     row,
  input  logic [2:0]           rgb0,
  input  logic [2:0]           rgb1,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [ROW_W+5:0]     wr_addr,
  output logic [5:0]           wr_data,
  output logic [PLANE_W-1:0]   wr_plane,
  output logic                 frame_done,
  output logic [ON_W-1:0]      on_cycles,
  output logic                 err_len,
  output logic                 err_ovf
);

  logic              lp_s, lp_rise;
  logic              latch_s, latch_rise;
  logic              noe_s, noe_rise;
  logic [ROW_W+5:0]  bus_s, bus_rise;
  logic              unused_sync;

  hub75_sync #(.W(1), .RST_VAL(1'b0)) u_lp_sync (
    .clk(clk), .rst(rst), .d(lp_clk), .q(lp_s), .rise(lp_rise)
  );
  hub75_sync #(.W(1), .RST_VAL(1'b0)) u_latch_sync (
    .clk(clk), .rst(rst), .d(latch), .q(latch_s), .rise(latch_rise)
  );
  hub75_sync #(.W(1), .RST_VAL(1'b1)) u_noe_sync (
    .clk(clk), .rst(rst), .d(noe), .q(noe_s), .rise(noe_rise)
  );
  hub75_sync #(.W(ROW_W + 6), .RST_VAL('0)) u_bus_sync (
    .clk(clk), .rst(rst), .d({row, rgb0, rgb1}), .q(bus_s), .rise(bus_rise)
  );

  assign unused_sync = ^{lp_s, latch_s, noe_rise, bus_rise};

  logic [ROW_W-1:0] row_s;
  pixel_t           pix_s;
  assign row_s = bus_s[ROW_W+5:6];
  assign pix_s = pixel_t'(bus_s[5:0]);

  drain_state_t       state_reg;
  logic [COL_W-1:0]   col_cnt_reg;
  logic               line_bad_reg;
  logic [IDX_W-1:0]   dcol_reg;
  logic [ROW_W-1:0]   wr_row_reg;
  logic [PLANE_W-1:0] wr_plane_reg;
  pixel_t             wr_data_reg;
  logic               wr_valid_reg;
  logic               frame_done_reg;
  logic [ROW_W-1:0]   prev_row_reg;
  logic               have_prev_reg;
  logic [PLANE_W-1:0] plane_reg;
  logic [ON_W-1:0]    timer_reg;
  logic [ON_W-1:0]    on_cycles_reg;
  logic               err_len_reg;
  logic               err_ovf_reg;

  pixel_t buf_a [COLS];
  pixel_t buf_b [COLS];
  pixel_t a_view [COLS];

  logic               shift_ok, shift_ovf, busy, line_ok, accept;
  logic [COL_W-1:0]   col_eff;
  logic [PLANE_W-1:0] plane_new;
  logic [IDX_W-1:0]   dcol_inc;

  // A shift landing in the same cycle as the latch counts toward that line.
  assign shift_ok  = lp_rise && (col_cnt_reg < COL_W'(COLS));
  assign shift_ovf = lp_rise && (col_cnt_reg == COL_W'(COLS));
  assign col_eff   = col_cnt_reg + COL_W'(shift_ok);
  assign busy      = (state_reg != IDLE);
  assign line_ok   = (col_eff == COL_W'(COLS)) && !line_bad_reg && !shift_ovf;
  assign accept    = latch_rise && !busy && line_ok;
  assign plane_new = next_plane(have_prev_reg, row_s == prev_row_reg, plane_reg);
  assign dcol_inc  = dcol_reg + 1'b1;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic hit;
    assign hit        = shift_ok && (col_cnt_reg[IDX_W-1:0] == IDX_W'(gi));
    assign a_view[gi] = hit ? pix_s : buf_a[gi];

    always_ff @(posedge clk) begin
      if (hit) buf_a[gi] <= pix_s;
      if (accept) buf_b[gi] <= a_view[gi];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      col_cnt_reg    <= '0;
      line_bad_reg   <= 1'b0;
      dcol_reg       <= '0;
      wr_row_reg     <= '0;
      wr_plane_reg   <= '0;
      wr_data_reg    <= '0;
      wr_valid_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      prev_row_reg   <= '0;
      have_prev_reg  <= 1'b0;
      plane_reg      <= '0;
      timer_reg      <= '0;
      on_cycles_reg  <= '0;
      err_len_reg    <= 1'b0;
      err_ovf_reg    <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;

      if (shift_ok) col_cnt_reg <= col_cnt_reg + 1'b1;
      if (shift_ovf) begin
        err_len_reg  <= 1'b1;
        line_bad_reg <= 1'b1;
      end

      if (latch_rise) begin
        on_cycles_reg <= timer_reg;
        timer_reg     <= '0;
      end else if (!noe_s && (timer_reg != '1)) begin
        timer_reg <= timer_reg + 1'b1;
      end

      // Every latch restarts the column count and feeds plane tracking,
      // whether or not the line itself is kept.
      if (latch_rise) begin
        col_cnt_reg   <= '0;
        line_bad_reg  <= 1'b0;
        prev_row_reg  <= row_s;
        have_prev_reg <= 1'b1;
        plane_reg     <= plane_new;
        if (busy) err_ovf_reg <= 1'b1;
        if (!line_ok) err_len_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg    <= DRAIN;
            wr_valid_reg <= 1'b1;
            wr_row_reg   <= row_s;
            wr_plane_reg <= plane_new;
            dcol_reg     <= '0;
            wr_data_reg  <= a_view[0];
          end
        end
        DRAIN: begin
          if (wr_ready) begin
            if (dcol_reg == IDX_W'(COLS - 1)) begin
              state_reg      <= IDLE;
              wr_valid_reg   <= 1'b0;
              frame_done_reg <= (wr_row_reg == ROW_W'(LAST_ROW)) &&
                                (wr_plane_reg == PLANE_W'(PLANES - 1));
            end else begin
              dcol_reg    <= dcol_inc;
              wr_data_reg <= buf_b[dcol_inc];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wr_valid   = wr_valid_reg;
  assign wr_addr    = {wr_row_reg, dcol_reg};
  assign wr_data    = wr_data_reg;
  assign wr_plane   = wr_plane_reg;
  assign frame_done = frame_done_reg;
  assign on_cycles  = on_cycles_reg;
  assign err_len    = err_len_reg;
  assign err_ovf    = err_ovf_reg;

endmodule
